// File: rtl/rv32i_pipe_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_pipe_pkg
// Shared definitions for the 5-stage RV32I pipeline control logic.
//   - REG_ADDR_W            : architectural register index width
//   - FWD_REGFILE/MEM/WB    : EX operand forward-select encodings
//   - hz_state_e            : hazard controller FSM states
//   - WAIT_CNT_W            : width of the memory wait-state counter
// ----------------------------------------------------------------------------
package rv32i_pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WAIT_CNT_W = 8;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;

    typedef enum logic {
        HZ_RUN  = 1'b0,
        HZ_WAIT = 1'b1
    } hz_state_e;

endpackage : rv32i_pipe_pkg

// File: rtl/fwd_select.sv
// ----------------------------------------------------------------------------
// fwd_select
// Combinational forward-select for one EX operand.
// Ports:
//   rs        in  ADDR_W  EX source register of this operand
//   mem_rd    in  ADDR_W  destination of the instruction in MEM
//   mem_wr    in  1       MEM instruction writes a register
//   mem_load  in  1       MEM instruction is a load (result not ready yet)
//   wb_rd     in  ADDR_W  destination of the instruction in WB
//   wb_wr     in  1       WB instruction writes a register
//   sel       out 2       FWD_REGFILE / FWD_MEM / FWD_WB
// The younger (MEM) producer wins over WB; x0 is never forwarded.
// ----------------------------------------------------------------------------
module fwd_select
    import rv32i_pipe_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              mem_wr,
    input  logic              mem_load,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              wb_wr,
    output logic [1:0]        sel
);

    // Per-operand producer priority: MEM (non-load) first, then WB.
    always_comb begin
        sel = FWD_REGFILE;
        if (mem_wr && (mem_rd != {ADDR_W{1'b0}}) && !mem_load && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_wr && (wb_rd != {ADDR_W{1'b0}}) && (wb_rd == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REGFILE;
        end
    end

endmodule : fwd_select

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall / flush / forward controller for the 5-stage RV32I pipeline.
// Optional build macro: HAZARD_PERF_CNT_EN adds perf_stall_cycles and
// perf_flush_count outputs.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   id_valid, id_rs1/2, id_uses_*  ID-stage instruction and its sources
//   ex_rs1/2, ex_rd, ex_reg_write  ID/EX register outputs
//   ex_is_load, ex_branch_taken    EX is a load / resolved a taken branch
//   mem_req, mem_ready             data-memory handshake of the MEM stage
//   pc_en, ifid_en, idex_en,
//   exmem_en                       stage-register enables
//   ifid_flush, idex_flush         synchronous clears of IF/ID and ID/EX
//   fwd_a_sel, fwd_b_sel           EX operand forward selects
//   mem_timeout                    one-cycle pulse on wait-state overflow
//   perf_stall_cycles,
//   perf_flush_count               (HAZARD_PERF_CNT_EN only) event counters
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_is_load,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_count
`endif
);

    import rv32i_pipe_pkg::*;

    // Pulse fires during the WAIT cycle whose ordinal equals WAIT_TIMEOUT,
    // i.e. when the count of already-completed WAIT cycles is one less.
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_MATCH = WAIT_CNT_W'(WAIT_TIMEOUT - 1);
    localparam bit                    TIMEOUT_EN    = (WAIT_TIMEOUT != 0);
    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_MAX  = {WAIT_CNT_W{1'b1}};

    hz_state_e             state_r;
    hz_state_e             state_next_s;
    logic [WAIT_CNT_W-1:0] wait_cnt_r;

    logic [REG_ADDR_W-1:0] mem_rd_r;
    logic                  mem_wr_r;
    logic                  mem_load_r;
    logic [REG_ADDR_W-1:0] wb_rd_r;
    logic                  wb_wr_r;

    logic                  freeze_s;
    logic                  load_use_s;
    logic [1:0]            fwd_a_raw_s;
    logic [1:0]            fwd_b_raw_s;

    assign freeze_s = mem_req && !mem_ready;

    assign load_use_s = id_valid && ex_is_load && ex_reg_write
                     && (ex_rd != {REG_ADDR_W{1'b0}})
                     && ((id_uses_rs1 && (id_rs1 == ex_rd))
                      || (id_uses_rs2 && (id_rs2 == ex_rd)));

    // FSM next state plus prioritised stage controls.
    always_comb begin
        state_next_s = state_r;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        mem_timeout  = 1'b0;

        case (state_r)
            HZ_RUN: begin
                if (freeze_s) begin
                    state_next_s = HZ_WAIT;
                end else begin
                    state_next_s = HZ_RUN;
                end
            end
            HZ_WAIT: begin
                if (mem_ready) begin
                    state_next_s = HZ_RUN;
                end else begin
                    state_next_s = HZ_WAIT;
                end
            end
            default: begin
                state_next_s = HZ_RUN;
            end
        endcase

        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (freeze_s) begin
            // Whole pipe holds; branch/load-use are re-seen after release.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (ex_branch_taken) begin
            // Squashes the ID instruction, so a load-use there is moot.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use_s) begin
            // Hold PC and IF/ID, insert one bubble into EX.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
        end

        if (!rst && TIMEOUT_EN && (state_r == HZ_WAIT) && (wait_cnt_r == TIMEOUT_MATCH)) begin
            mem_timeout = 1'b1;
        end else begin
            mem_timeout = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= HZ_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Consecutive WAIT-cycle counter, saturating so the pulse cannot repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= {WAIT_CNT_W{1'b0}};
        end else if (state_r == HZ_RUN) begin
            wait_cnt_r <= {WAIT_CNT_W{1'b0}};
        end else if (wait_cnt_r != WAIT_CNT_MAX) begin
            wait_cnt_r <= wait_cnt_r + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Shadow of MEM/WB destinations, advancing with the EX/MEM register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_r   <= {REG_ADDR_W{1'b0}};
            mem_wr_r   <= 1'b0;
            mem_load_r <= 1'b0;
            wb_rd_r    <= {REG_ADDR_W{1'b0}};
            wb_wr_r    <= 1'b0;
        end else if (exmem_en) begin
            mem_rd_r   <= ex_rd;
            mem_wr_r   <= ex_reg_write;
            mem_load_r <= ex_is_load;
            wb_rd_r    <= mem_rd_r;
            wb_wr_r    <= mem_wr_r;
        end else begin
            mem_rd_r   <= mem_rd_r;
            mem_wr_r   <= mem_wr_r;
            mem_load_r <= mem_load_r;
            wb_rd_r    <= wb_rd_r;
            wb_wr_r    <= wb_wr_r;
        end
    end

    fwd_select #(.ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs       (ex_rs1),
        .mem_rd   (mem_rd_r),
        .mem_wr   (mem_wr_r),
        .mem_load (mem_load_r),
        .wb_rd    (wb_rd_r),
        .wb_wr    (wb_wr_r),
        .sel      (fwd_a_raw_s)
    );

    fwd_select #(.ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs       (ex_rs2),
        .mem_rd   (mem_rd_r),
        .mem_wr   (mem_wr_r),
        .mem_load (mem_load_r),
        .wb_rd    (wb_rd_r),
        .wb_wr    (wb_wr_r),
        .sel      (fwd_b_raw_s)
    );

    // Forward selects fall back to the register file while in reset.
    always_comb begin
        if (rst) begin
            fwd_a_sel = FWD_REGFILE;
            fwd_b_sel = FWD_REGFILE;
        end else begin
            fwd_a_sel = fwd_a_raw_s;
            fwd_b_sel = fwd_b_raw_s;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Stall-cycle and taken-branch flush counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= 32'd0;
            perf_flush_count  <= 32'd0;
        end else begin
            if (!pc_en) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end else begin
                perf_stall_cycles <= perf_stall_cycles;
            end
            if (ifid_flush) begin
                perf_flush_count <= perf_flush_count + 32'd1;
            end else begin
                perf_flush_count <= perf_flush_count;
            end
        end
    end
`endif

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed scenarios with constant expectations, then a randomized run
// compared each cycle against a behavioural reference model.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2;
    logic       id_uses_rs1, id_uses_rs2;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       ex_reg_write, ex_is_load, ex_branch_taken;
    logic       mem_req, mem_ready;
    logic       pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: destination records of the MEM and WB slots.
    logic [4:0]  m_mem_rd, m_wb_rd;
    bit          m_mem_wr, m_mem_load, m_wb_wr;
    bit          m_waiting;
    int          m_wait_cycles;
    logic [31:0] m_stall, m_flush;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .WAIT_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
`endif
    );

    // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, mem_timeout}
    function automatic logic [6:0] obs_ctrl();
        return {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, mem_timeout};
    endfunction

    // Expected controls straight from the priority list.
    function automatic logic [6:0] exp_ctrl();
        bit lu;
        bit to;
        lu = id_valid && ex_is_load && ex_reg_write && (ex_rd != 5'd0)
          && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        to = m_waiting && (m_wait_cycles + 1 == TO);
        if (rst)                        return 7'b0000110;
        else if (mem_req && !mem_ready) return {6'b000000, to};
        else if (ex_branch_taken)       return {6'b111111, to};
        else if (lu)                    return {6'b001101, to};
        else                            return {6'b111100, to};
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (rst) return 2'b00;
        if (m_mem_wr && m_mem_rd != 5'd0 && !m_mem_load && m_mem_rd == rs) return 2'b01;
        if (m_wb_wr && m_wb_rd != 5'd0 && m_wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic set_idle();
        rst = 1'b0; id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        ex_rd = 5'd0; ex_reg_write = 1'b0; ex_is_load = 1'b0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic settle();
        #3;
    endtask

    // Advance one clock and move the reference model along with it.
    task automatic tick();
        logic [6:0] e;
        e = exp_ctrl();
        @(posedge clk);
        if (rst) begin
            m_mem_rd = 5'd0; m_mem_wr = 1'b0; m_mem_load = 1'b0;
            m_wb_rd = 5'd0; m_wb_wr = 1'b0;
            m_waiting = 1'b0; m_wait_cycles = 0;
            m_stall = 32'd0; m_flush = 32'd0;
        end else begin
            if (!e[6]) m_stall = m_stall + 32'd1;
            if (e[2])  m_flush = m_flush + 32'd1;
            if (e[3]) begin
                m_wb_rd = m_mem_rd; m_wb_wr = m_mem_wr;
                m_mem_rd = ex_rd; m_mem_wr = ex_reg_write; m_mem_load = ex_is_load;
            end
            if (!m_waiting) begin
                if (mem_req && !mem_ready) begin
                    m_waiting = 1'b1; m_wait_cycles = 0;
                end
            end else begin
                m_wait_cycles++;
                if (mem_ready) m_waiting = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1; ex_branch_taken = 1'b1; mem_req = 1'b1; ex_rs1 = 5'd3; ex_rs2 = 5'd3;
        settle();
        tests_run++;
        if (obs_ctrl() !== 7'b0000110) begin
            tests_failed++; $display("FAIL reset_ctrl: got %b expected %b", obs_ctrl(), 7'b0000110);
        end
        tests_run++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_fwd: got %b expected %b", {fwd_a_sel, fwd_b_sel}, 4'b0000);
        end
        tick();
        set_idle();
        settle();
        tests_run++;
        if (obs_ctrl() !== 7'b1111000) begin
            tests_failed++; $display("FAIL post_reset_ctrl: got %b expected %b", obs_ctrl(), 7'b1111000);
        end
        tick();
    endtask

    task automatic test_load_use();
        set_idle(); tick(); tick();
        ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
        id_valid = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b1; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
        settle();
        tests_run++;
        if (obs_ctrl() !== 7'b0011010) begin
            tests_failed++; $display("FAIL load_use_stall: got %b expected %b", obs_ctrl(), 7'b0011010);
        end
        tick();
        // bubble now in EX, load in MEM: no second stall, no forward from a load
        ex_is_load = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0; ex_rs1 = 5'd5;
        settle();
        tests_run++;
        if (obs_ctrl() !== 7'b1111000) begin
            tests_failed++; $display("FAIL load_use_release: got %b expected %b", obs_ctrl(), 7'b1111000);
        end
        tests_run++;
        if (fwd_a_sel !== 2'b00) begin
            tests_failed++; $display("FAIL load_in_mem_fwd: got %b expected %b", fwd_a_sel, 2'b00);
        end
        tick();
        // dependent add in EX, load in WB
        id_valid = 1'b0; ex_rs1 = 5'd5; ex_rs2 = 5'd0; ex_reg_write = 1'b1; ex_rd = 5'd6;
        settle();
        tests_run++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b1000) begin
            tests_failed++; $display("FAIL load_use_wb_fwd: got %b expected %b", {fwd_a_sel, fwd_b_sel}, 4'b1000);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0] rs1_t [6] = '{5'd0, 5'd3, 5'd9, 5'd0, 5'd4, 5'd4};
        logic [4:0] rs2_t [6] = '{5'd0, 5'd1, 5'd3, 5'd4, 5'd0, 5'd4};
        logic [4:0] rd_t  [6] = '{5'd3, 5'd4, 5'd0, 5'd4, 5'd4, 5'd0};
        logic       wr_t  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] exp_t [6] = '{4'b0000, 4'b0100, 4'b0010, 4'b0010, 4'b0100, 4'b0101};
        set_idle(); tick(); tick();
        for (int i = 0; i < 6; i++) begin
            ex_rs1 = rs1_t[i]; ex_rs2 = rs2_t[i]; ex_rd = rd_t[i]; ex_reg_write = wr_t[i];
            settle();
            tests_run++;
            if ({fwd_a_sel, fwd_b_sel} !== exp_t[i]) begin
                tests_failed++;
                $display("FAIL alu_fwd[%0d]: got %b expected %b", i, {fwd_a_sel, fwd_b_sel}, exp_t[i]);
            end
            tick();
        end
    endtask

    task automatic test_branch_loaduse();
        set_idle(); tick();
        ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
        id_valid = 1'b1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; ex_branch_taken = 1'b1;
        settle();
        tests_run++;
        if (obs_ctrl() !== 7'b1111110) begin
            tests_failed++; $display("FAIL branch_over_load_use: got %b expected %b", obs_ctrl(), 7'b1111110);
        end
        tick();
        set_idle(); tick(); tick();
    endtask

    task automatic test_mem_wait();
        set_idle(); tick();
        mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            tests_run++;
            if (obs_ctrl() !== 7'b0000000) begin
                tests_failed++; $display("FAIL mem_wait_freeze[%0d]: got %b expected %b", i, obs_ctrl(), 7'b0000000);
            end
            tick();
        end
        mem_ready = 1'b1;
        settle();
        tests_run++;
        if (obs_ctrl() !== 7'b1111110) begin
            tests_failed++; $display("FAIL mem_wait_release_branch: got %b expected %b", obs_ctrl(), 7'b1111110);
        end
        tick();
        set_idle();
        settle();
        tests_run++;
        if (obs_ctrl() !== 7'b1111000) begin
            tests_failed++; $display("FAIL mem_wait_after: got %b expected %b", obs_ctrl(), 7'b1111000);
        end
        tick();
    endtask

    task automatic test_timeout();
        set_idle(); tick();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            settle();
            tests_run++;
            if (obs_ctrl() !== {6'b000000, (i == 4)}) begin
                tests_failed++;
                $display("FAIL timeout[%0d]: got %b expected %b", i, obs_ctrl(), {6'b000000, (i == 4)});
            end
            tick();
        end
        mem_ready = 1'b1;
        settle();
        tests_run++;
        if (obs_ctrl() !== 7'b1111000) begin
            tests_failed++; $display("FAIL timeout_release: got %b expected %b", obs_ctrl(), 7'b1111000);
        end
        tick();
        set_idle(); tick();
    endtask

    task automatic test_reset_in_wait();
        set_idle(); tick();
        ex_rd = 5'd7; ex_reg_write = 1'b1;
        tick();
        ex_rd = 5'd0; ex_reg_write = 1'b0; ex_rs1 = 5'd7;
        mem_req = 1'b1; mem_ready = 1'b0;
        tick(); tick();
        rst = 1'b1;
        settle();
        tests_run++;
        if ({obs_ctrl(), fwd_a_sel} !== 9'b000011000) begin
            tests_failed++; $display("FAIL reset_in_wait: got %b expected %b", {obs_ctrl(), fwd_a_sel}, 9'b000011000);
        end
        tick();
        rst = 1'b0; mem_req = 1'b0;
        settle();
        tests_run++;
        if ({obs_ctrl(), fwd_a_sel} !== 9'b111100000) begin
            tests_failed++; $display("FAIL after_reset_shadow: got %b expected %b", {obs_ctrl(), fwd_a_sel}, 9'b111100000);
        end
        tick();
        // counter restarts from zero: pulse again on the 4th WAIT cycle
        mem_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            tests_run++;
            if (mem_timeout !== (i == 4)) begin
                tests_failed++; $display("FAIL after_reset_timeout[%0d]: got %b expected %b", i, mem_timeout, (i == 4));
            end
            tick();
        end
        mem_ready = 1'b1; tick();
        set_idle(); tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            rst             = ($urandom_range(0, 49) == 0);
            id_valid        = 1'($urandom_range(0, 1));
            id_rs1          = 5'($urandom_range(0, 7));
            id_rs2          = 5'($urandom_range(0, 7));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            ex_rs1          = 5'($urandom_range(0, 7));
            ex_rs2          = 5'($urandom_range(0, 7));
            ex_rd           = 5'($urandom_range(0, 7));
            ex_reg_write    = ($urandom_range(0, 3) != 0);
            ex_is_load      = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            mem_req         = ($urandom_range(0, 2) == 0);
            mem_ready       = ($urandom_range(0, 2) == 0);
            settle();
            tests_run++;
            if (obs_ctrl() !== exp_ctrl()) begin
                tests_failed++; $display("FAIL rand_ctrl[%0d]: got %b expected %b", n, obs_ctrl(), exp_ctrl());
            end
            tests_run++;
            if ({fwd_a_sel, fwd_b_sel} !== {exp_fwd(ex_rs1), exp_fwd(ex_rs2)}) begin
                tests_failed++;
                $display("FAIL rand_fwd[%0d]: got %b expected %b", n, {fwd_a_sel, fwd_b_sel},
                         {exp_fwd(ex_rs1), exp_fwd(ex_rs2)});
            end
`ifdef HAZARD_PERF_CNT_EN
            tests_run++;
            if ({perf_stall_cycles, perf_flush_count} !== {m_stall, m_flush}) begin
                tests_failed++;
                $display("FAIL rand_perf[%0d]: got %0d/%0d expected %0d/%0d", n,
                         perf_stall_cycles, perf_flush_count, m_stall, m_flush);
            end
`endif
            tick();
        end
    endtask

    initial begin
        m_mem_rd = 5'd0; m_wb_rd = 5'd0; m_mem_wr = 1'b0; m_mem_load = 1'b0; m_wb_wr = 1'b0;
        m_waiting = 1'b0; m_wait_cycles = 0; m_stall = 32'd0; m_flush = 32'd0;
        test_reset();
        test_load_use();
        test_back_to_back();
        test_branch_loaduse();
        test_mem_wait();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
